// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: owns the single port of the instruction ROM and shares it
// between the fetch stage (reads) and the UART program loader (writes).
//
// state     | meaning
// ----------+----------------------------------------------------------------
// ST_FETCH  | port belongs to the fetch stage; load_req is sampled here only
// ST_DRAIN  | one idle cycle so the read issued last cycle can return
// ST_LOAD   | port belongs to the loader; CPU stalled; writes accepted
// ST_RESUME | one idle cycle pulsing cpu_restart so the PC returns to 0
module imem_port_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_rdata,
  output logic              fetch_valid,
  output logic              cpu_stall,
  output logic              cpu_restart,
  input  logic              load_req,
  input  logic              load_done,
  input  logic              load_wvalid,
  input  logic [ADDR_W-1:0] load_waddr,
  input  logic [DATA_W-1:0] load_wdata,
  output logic              load_wready,
  output logic [ADDR_W:0]   load_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LOAD   = 2'd2,
    ST_RESUME = 2'd3
  } state_t;

  // load_count saturates at 2^ADDR_W, i.e. a full image.
  localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic [ADDR_W:0] count_q, count_d;

  // Next state, port mux and handshake outputs; the port is idle by default.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    fetch_valid_d = 1'b0;
    cpu_stall     = 1'b1;
    cpu_restart   = 1'b0;
    load_wready   = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;

    unique case (state_q)
      ST_FETCH: begin
        if (load_req) begin
          // No fetch is issued in the cycle the loader is granted.
          state_d = ST_DRAIN;
          count_d = '0;
        end else begin
          cpu_stall     = 1'b0;
          mem_en        = fetch_req;
          mem_addr      = fetch_addr;
          fetch_valid_d = fetch_req;
        end
      end
      ST_DRAIN: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load_wready = 1'b1;
        if (load_wvalid) begin
          mem_en    = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = load_waddr;
          mem_wdata = load_wdata;
          if (count_q != COUNT_MAX) begin
            count_d = count_q + COUNT_ONE;
          end
        end
        // A write offered alongside load_done is still performed above.
        if (load_done) begin
          state_d = ST_RESUME;
        end
      end
      ST_RESUME: begin
        cpu_restart = 1'b1;
        state_d     = ST_FETCH;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Hold the CPU and keep the ROM port quiet while reset is asserted.
    if (!reset) begin
      cpu_stall     = 1'b1;
      cpu_restart   = 1'b0;
      load_wready   = 1'b0;
      mem_en        = 1'b0;
      mem_we        = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      fetch_valid_d = 1'b0;
    end
  end

  // State, fetch-valid pipeline bit and session word counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      fetch_valid_q <= 1'b0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      fetch_valid_q <= fetch_valid_d;
      count_q       <= count_d;
    end
  end

  assign fetch_valid = fetch_valid_q;
  assign fetch_rdata = mem_rdata;
  assign load_count  = count_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: a synchronous ROM model on the port, a shadow
// image of the expected ROM contents, and a queue of expected fetch words.
module tb_imem_port_arbiter;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          fetch_req = 1'b0;
  logic [AW-1:0] fetch_addr = '0;
  logic [DW-1:0] fetch_rdata;
  logic          fetch_valid;
  logic          cpu_stall;
  logic          cpu_restart;
  logic          load_req = 1'b0;
  logic          load_done = 1'b0;
  logic          load_wvalid = 1'b0;
  logic [AW-1:0] load_waddr = '0;
  logic [DW-1:0] load_wdata = '0;
  logic          load_wready;
  logic [AW:0]   load_count;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int total = 0;
  int bad = 0;
  int restarts = 0;
  int r0;

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] rom [DEPTH];
  logic [DW-1:0] rom_rdata = '0;
  logic          rom_ready = 1'b0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] mon_exp;

  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_rdata(fetch_rdata), .fetch_valid(fetch_valid),
    .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
    .load_req(load_req), .load_done(load_done),
    .load_wvalid(load_wvalid), .load_waddr(load_waddr), .load_wdata(load_wdata),
    .load_wready(load_wready), .load_count(load_count),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  // Synchronous single-port ROM/BRAM model, preloaded on the first edge.
  always @(posedge clock) begin
    if (!rom_ready) begin
      for (int i = 0; i < DEPTH; i++) rom[i] <= 32'hC0DE0000 + i;
      rom_ready <= 1'b1;
    end else if (mem_en) begin
      if (mem_we) rom[mem_addr] <= mem_wdata;
      else        rom_rdata <= rom[mem_addr];
    end
  end
  assign mem_rdata = rom_rdata;

  // Scoreboard consumer: every fetch_valid must match the oldest expected word.
  always @(negedge clock) begin
    if (cpu_restart === 1'b1) restarts++;
    if (reset && fetch_valid === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL fetch_unexpected: fetch_valid=1 rdata=%h, required no valid", fetch_rdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fetch_rdata !== mon_exp) begin
          bad++;
          $display("FAIL fetch_data: rdata=%h required=%h", fetch_rdata, mon_exp);
        end
      end
    end
  end

  task automatic drive_idle();
    fetch_req = 1'b0; load_req = 1'b0; load_done = 1'b0; load_wvalid = 1'b0;
  endtask

  task automatic fetch_burst(input int first, input int n, input int stride);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      fetch_req  = 1'b1;
      fetch_addr = AW'(first + k * stride);
      exp_q.push_back(exp_mem[first + k * stride]);
      #1;
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== AW'(first + k * stride)) begin
        bad++;
        $display("FAIL fetch_port: en=%b we=%b addr=%0d required en=1 we=0 addr=%0d",
                 mem_en, mem_we, mem_addr, first + k * stride);
      end
    end
    @(negedge clock);
    fetch_req = 1'b0;
    @(negedge clock);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL fetch_missing: %0d words never returned, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    fetch_req = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    total++;
    if (cpu_stall !== 1'b1) begin bad++; $display("FAIL rst_stall: got=%b required=1", cpu_stall); end
    total++;
    if (fetch_valid !== 1'b0 || cpu_restart !== 1'b0) begin
      bad++; $display("FAIL rst_flags: valid=%b restart=%b required 0 0", fetch_valid, cpu_restart);
    end
    total++;
    if (load_count !== '0 || load_wready !== 1'b0 || mem_en !== 1'b0) begin
      bad++; $display("FAIL rst_port: count=%0d wready=%b en=%b required 0 0 0", load_count, load_wready, mem_en);
    end
    @(negedge clock);
    fetch_req = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b0) begin bad++; $display("FAIL rst_release_stall: got=%b required=0", cpu_stall); end
  endtask

  task automatic test_fetch_seq();
    fetch_burst(0, 3, 1);
    total++;
    if (cpu_stall !== 1'b0) begin bad++; $display("FAIL fetch_stall: got=%b required=0", cpu_stall); end
  endtask

  task automatic test_drain();
    @(negedge clock);
    fetch_req = 1'b1; fetch_addr = AW'(5);
    exp_q.push_back(exp_mem[5]);
    @(negedge clock);
    fetch_addr = AW'(6);
    load_req = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b1 || mem_en !== 1'b0) begin
      bad++; $display("FAIL drain_grant: stall=%b en=%b required 1 0", cpu_stall, mem_en);
    end
    @(negedge clock);
    fetch_req = 1'b0; load_req = 1'b0;
    #1;
    total++;
    if (cpu_stall !== 1'b1 || mem_en !== 1'b0 || load_wready !== 1'b0 || load_count !== '0) begin
      bad++; $display("FAIL drain_idle: stall=%b en=%b wready=%b count=%0d required 1 0 0 0",
                      cpu_stall, mem_en, load_wready, load_count);
    end
    @(negedge clock);
    #1;
    total++;
    if (load_wready !== 1'b1 || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL load_enter: wready=%b stall=%b required 1 1", load_wready, cpu_stall);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL drain_word: %0d words never returned, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_load_writes();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      load_wvalid = 1'b1; load_waddr = AW'(k); load_wdata = 32'hA0 + k;
      exp_mem[k] = 32'hA0 + k;
      #1;
      total++;
      if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== AW'(k) || mem_wdata !== 32'hA0 + k) begin
        bad++; $display("FAIL load_write: en=%b we=%b addr=%0d data=%h required 1 1 %0d %h",
                        mem_en, mem_we, mem_addr, mem_wdata, k, 32'hA0 + k);
      end
      if (k % 2 == 1) begin
        @(negedge clock);
        load_wvalid = 1'b0;
        #1;
        total++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
          bad++; $display("FAIL load_gap: en=%b we=%b required 0 0", mem_en, mem_we);
        end
      end
    end
    @(negedge clock);
    load_wvalid = 1'b0;
    #1;
    total++;
    if (load_count !== 15'd4) begin bad++; $display("FAIL load_count4: got=%0d required=4", load_count); end
  endtask

  task automatic test_done_with_write();
    r0 = restarts;
    @(negedge clock);
    load_wvalid = 1'b1; load_waddr = AW'(7); load_wdata = 32'hA7; load_done = 1'b1;
    exp_mem[7] = 32'hA7;
    #1;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(7)) begin
      bad++; $display("FAIL done_write: we=%b addr=%0d required 1 7", mem_we, mem_addr);
    end
    @(negedge clock);
    drive_idle();
    #1;
    total++;
    if (cpu_restart !== 1'b1 || cpu_stall !== 1'b1 || mem_en !== 1'b0 || load_wready !== 1'b0) begin
      bad++; $display("FAIL resume: restart=%b stall=%b en=%b wready=%b required 1 1 0 0",
                      cpu_restart, cpu_stall, mem_en, load_wready);
    end
    total++;
    if (load_count !== 15'd5) begin bad++; $display("FAIL done_count: got=%0d required=5", load_count); end
    @(negedge clock);
    #1;
    total++;
    if (cpu_restart !== 1'b0 || cpu_stall !== 1'b0 || load_count !== 15'd5) begin
      bad++; $display("FAIL back_to_fetch: restart=%b stall=%b count=%0d required 0 0 5",
                      cpu_restart, cpu_stall, load_count);
    end
    total++;
    if (restarts - r0 != 1) begin bad++; $display("FAIL restart_pulses: got=%0d required=1", restarts - r0); end
    fetch_burst(0, 4, 1);
    fetch_burst(7, 1, 1);
  endtask

  task automatic test_reset_mid_load();
    @(negedge clock); load_req = 1'b1;
    @(negedge clock); load_req = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      load_wvalid = 1'b1; load_waddr = AW'(10 + k); load_wdata = 32'hB0 + k;
      exp_mem[10 + k] = 32'hB0 + k;
      @(negedge clock);
    end
    load_wvalid = 1'b0;
    #1;
    total++;
    if (load_count !== 15'd3) begin bad++; $display("FAIL mid_count3: got=%0d required=3", load_count); end
    r0 = restarts;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (load_count !== '0 || cpu_stall !== 1'b1 || load_wready !== 1'b0 || mem_en !== 1'b0) begin
      bad++; $display("FAIL mid_reset: count=%0d stall=%b wready=%b en=%b required 0 1 0 0",
                      load_count, cpu_stall, load_wready, mem_en);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    total++;
    if (cpu_stall !== 1'b0 || load_wready !== 1'b0) begin
      bad++; $display("FAIL mid_fetch: stall=%b wready=%b required 0 0", cpu_stall, load_wready);
    end
    repeat (3) @(negedge clock);
    total++;
    if (restarts != r0) begin bad++; $display("FAIL mid_restart: pulses=%0d required=0", restarts - r0); end
    fetch_burst(10, 3, 1);
  endtask

  task automatic test_wvalid_in_fetch();
    @(negedge clock);
    load_wvalid = 1'b1; load_waddr = AW'(9); load_wdata = 32'hDEADBEEF;
    #1;
    total++;
    if (load_wready !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
      bad++; $display("FAIL fetch_wvalid: wready=%b we=%b stall=%b required 0 0 0", load_wready, mem_we, cpu_stall);
    end
    @(negedge clock);
    load_wvalid = 1'b0;
    fetch_burst(9, 1, 1);
  endtask

  task automatic test_saturate();
    @(negedge clock); load_req = 1'b1;
    @(negedge clock); load_req = 1'b0;
    @(negedge clock);
    for (int k = 0; k < DEPTH + 2; k++) begin
      load_wvalid = 1'b1; load_waddr = AW'(k); load_wdata = 32'h5A000000 + k;
      exp_mem[k % DEPTH] = 32'h5A000000 + k;
      @(negedge clock);
    end
    load_wvalid = 1'b0;
    #1;
    total++;
    if (load_count !== 15'h4000) begin bad++; $display("FAIL sat_count: got=%0d required=%0d", load_count, DEPTH); end
    @(negedge clock); load_done = 1'b1;
    @(negedge clock); load_done = 1'b0;
    @(negedge clock);
    #1;
    total++;
    if (load_count !== 15'h4000 || cpu_stall !== 1'b0) begin
      bad++; $display("FAIL sat_hold: count=%0d stall=%b required %0d 0", load_count, cpu_stall, DEPTH);
    end
    fetch_burst(0, 3, 1);
    fetch_burst(DEPTH - 1, 1, 1);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = 32'hC0DE0000 + i;
    test_reset();
    test_fetch_seq();
    test_drain();
    test_load_writes();
    test_done_with_write();
    test_reset_mid_load();
    test_wvalid_in_fetch();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
